instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
Parametrised, synchronous-read instruction memory for the pipelined core's IF stage. It supersedes the combinational word-indexed code ROM and adds:
- registered fetch output with stall/flush control;
- word or byte PC addressing;
- alignment and range fault detection;
- a runtime program-load write port;
- an optional post-reset clear sequence.

Parameters:
ADDR_W, 8, index width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction width
BYTE_ADDR, 0, 0: pc is a word index; 1: pc is a byte address (idx = pc[ADDR_W+1:2])
CLEAR_ON_RESET, 1, 1: fill memory with NOP after reset before accepting fetches
NOP, 0, instruction value driven on bubble/fault/clear (DATA_W bits)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
fetch_en  in  1  IF stage requests a fetch this cycle
stall  in  1  hold current instr/instr_valid/fault
flush  in  1  kill fetch, insert bubble (priority over stall)
pc  in  32  fetch address
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  instr is a real fetch result
fault  out  1  last fetch was misaligned or out of range
ready  out  1  memory usable (clear sequence complete)
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_W  program-load word index
prog_data  in  DATA_W  program-load data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - instr=NOP, instr_valid=0, fault=0, clear counter=0.
  - FSM enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - ready=0 in CLEAR, 1 in RUN.
  - Memory array is not reset except by CLEAR.
- FSM states:
  - CLEAR: writes NOP to mem[cnt] each cycle, cnt increments 0..DEPTH-1. After writing DEPTH-1, next state is RUN and ready=1 on the following cycle. fetch_en, prog_we, stall and flush are ignored; outputs hold their reset values. Duration is exactly DEPTH cycles after rst_n deasserts.
  - RUN: terminal until reset.
- Index and fault decode (combinational, from pc):
  - BYTE_ADDR=0: idx=pc[ADDR_W-1:0]. Range fault if pc[31:ADDR_W]!=0.
  - BYTE_ADDR=1: idx=pc[ADDR_W+1:2]. Misaligned fault if pc[1:0]!=0. Range fault if pc[31:ADDR_W+2]!=0.
  - bad = misaligned | range.
- Output register update in RUN, by priority:
  1. flush=1: instr<=NOP, instr_valid<=0, fault<=0.
  2. stall=1: all three hold.
  3. fetch_en=1 and bad: instr<=NOP, instr_valid<=0, fault<=1.
  4. fetch_en=1: instr<=mem[idx], instr_valid<=1, fault<=0.
  5. Otherwise: instr<=NOP, instr_valid<=0, fault<=0.
- Latency: exactly 1 cycle from pc/fetch_en sampled at edge N to instr valid after edge N.
- Program write: in RUN, prog_we=1 writes mem[prog_addr]<=prog_data at the clock edge. It is accepted regardless of stall/flush/fetch_en.
- Write/read collision: fetch (case 4) with idx==prog_addr and prog_we=1 in the same cycle returns prog_data (write-first).
- A stalled output keeps its captured value even if that address is rewritten during the stall. The new value appears on the next non-stalled fetch.
- Reset mid-CLEAR or mid-RUN: immediate return to reset values; CLEAR restarts at cnt=0.
- pc wrap: no increment logic inside; pc is owned by the IF stage.

Test Plan:
1. CLEAR_ON_RESET=1, ADDR_W=4: release rst_n -> ready=0 for 16 cycles then 1; fetches of pc=0..15 return 0 with instr_valid=1; fetch_en during CLEAR gives instr_valid=0.
2. Load mem[3]=32'h0000_1234 via prog port, then fetch pc=3 with BYTE_ADDR=0 -> instr=32'h0000_1234 one cycle later, instr_valid=1, fault=0. Same cycle, write mem[5]=32'hA5A5_A5A5 and fetch pc=5 -> instr=32'hA5A5_A5A5.
3. BYTE_ADDR=1: fetch pc=12 -> mem[3]; pc=13 -> instr=NOP, instr_valid=0, fault=1; pc=32'h0000_0100 with ADDR_W=4 -> fault=1.
4. Fetch pc=3 (valid), then stall=1 for 3 cycles while pc changes to 7 and mem[3] is rewritten -> instr stays 32'h0000_1234 with instr_valid=1. Release stall -> mem[7] next cycle.
5. stall=1 and flush=1 together -> instr=NOP, instr_valid=0, fault=0 next cycle; a prior fault=1 is cleared by flush.
6. Assert rst_n=0 asynchronously mid-RUN between clock edges -> instr=NOP, instr_valid=0, ready=0 immediately. After release, CLEAR runs a full DEPTH cycles and previously loaded words read back NOP.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the IF stage: registered fetch with stall/flush,
// word/byte PC decode with fault flags, program-load port and optional post-reset NOP fill.
module instr_mem_sync #(
    parameter int                 ADDR_W         = 8,
    parameter int                 DATA_W         = 32,
    parameter int                 BYTE_ADDR      = 0,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0]  NOP            = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    output logic              ready,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    // state   | meaning
    // S_CLEAR | filling mem with NOP, one word per cycle; fetch/program ports ignored
    // S_RUN   | normal fetch and program-load operation, terminal until reset
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam int DEPTH = 2**ADDR_W;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              misaligned, out_of_range, bad;
    logic [DATA_W-1:0] rd_data;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] instr_nxt;
    logic              valid_nxt, fault_nxt;

    generate
        if (BYTE_ADDR != 0) begin : g_byte
            assign idx          = pc[ADDR_W+1:2];
            assign misaligned   = |pc[1:0];
            assign out_of_range = (pc >> (ADDR_W + 2)) != 32'd0;
        end else begin : g_word
            assign idx          = pc[ADDR_W-1:0];
            assign misaligned   = 1'b0;
            assign out_of_range = (pc >> ADDR_W) != 32'd0;
        end
    endgenerate

    assign bad = misaligned | out_of_range;

    // Write-first: a same-cycle program write to the fetched word is forwarded.
    assign rd_data = (prog_we && (prog_addr == idx)) ? prog_data : mem[idx];

    assign ready = (state == S_RUN);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        fault_nxt = fault;
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = NOP;
                cnt_nxt   = cnt + ADDR_W'(1);
                if (cnt == {ADDR_W{1'b1}}) state_nxt = S_RUN;
            end
            S_RUN: begin
                mem_we = prog_we;
                if (flush) begin
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b0;
                end else if (stall) begin
                    instr_nxt = instr;
                end else if (fetch_en && bad) begin
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b1;
                end else if (fetch_en) begin
                    instr_nxt = rd_data;
                    valid_nxt = 1'b1;
                    fault_nxt = 1'b0;
                end else begin
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            cnt         <= '0;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fault       <= fault_nxt;
        end
    end

    // Array is deliberately outside the reset domain; only the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: word- and byte-addressed instances driven together and
// compared against a behavioural model, directed scenarios followed by random traffic.
module tb_instr_mem_sync;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fetch_en = 1'b0, stall = 1'b0, flush = 1'b0, prog_we = 1'b0;
    logic [31:0]   pc_w = '0, pc_b = '0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic [31:0]   instr_w, instr_b;
    logic          valid_w, valid_b, fault_w, fault_b, ready_w, ready_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [DEPTH];
    int          clear_left = DEPTH;
    logic [31:0] e_instr [2];
    logic        e_valid [2];
    logic        e_fault [2];

    always #5 clk = ~clk;

    instr_mem_sync #(.ADDR_W(AW), .DATA_W(32), .BYTE_ADDR(0), .CLEAR_ON_RESET(1), .NOP(32'h0)) u_word (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .stall(stall), .flush(flush), .pc(pc_w),
        .instr(instr_w), .instr_valid(valid_w), .fault(fault_w), .ready(ready_w),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

    instr_mem_sync #(.ADDR_W(AW), .DATA_W(32), .BYTE_ADDR(1), .CLEAR_ON_RESET(1), .NOP(32'h0)) u_byte (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .stall(stall), .flush(flush), .pc(pc_b),
        .instr(instr_b), .instr_valid(valid_b), .fault(fault_b), .ready(ready_b),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_bad(input int b, input logic [31:0] p);
        if (b == 0) return p >= 32'(DEPTH);
        return (p % 4 != 0) || (p >= 32'(4 * DEPTH));
    endfunction

    function automatic int to_idx(input int b, input logic [31:0] p);
        if (b == 0) return int'(p % 32'(DEPTH));
        return int'((p / 4) % 32'(DEPTH));
    endfunction

    task automatic compare_all();
        check("w_instr", instr_w, e_instr[0]);
        check("w_valid", 32'(valid_w), 32'(e_valid[0]));
        check("w_fault", 32'(fault_w), 32'(e_fault[0]));
        check("w_ready", 32'(ready_w), 32'(clear_left == 0));
        check("b_instr", instr_b, e_instr[1]);
        check("b_valid", 32'(valid_b), 32'(e_valid[1]));
        check("b_fault", 32'(fault_b), 32'(e_fault[1]));
        check("b_ready", 32'(ready_b), 32'(clear_left == 0));
    endtask

    // One clock: model the edge from the (stable) inputs, then compare after it.
    task automatic step();
        logic [31:0] pcs [2];
        int          i;
        pcs[0] = pc_w;
        pcs[1] = pc_b;
        @(posedge clk);
        if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = 32'h0;
            clear_left--;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (flush) begin
                    e_instr[b] = 0; e_valid[b] = 0; e_fault[b] = 0;
                end else if (stall) begin
                    e_instr[b] = e_instr[b];
                end else if (fetch_en && is_bad(b, pcs[b])) begin
                    e_instr[b] = 0; e_valid[b] = 0; e_fault[b] = 1;
                end else if (fetch_en) begin
                    i = to_idx(b, pcs[b]);
                    e_instr[b] = (prog_we && int'(prog_addr) == i) ? prog_data : m_mem[i];
                    e_valid[b] = 1; e_fault[b] = 0;
                end else begin
                    e_instr[b] = 0; e_valid[b] = 0; e_fault[b] = 0;
                end
            end
            if (prog_we) m_mem[prog_addr] = prog_data;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            e_instr[b] = 0; e_valid[b] = 0; e_fault[b] = 0;
        end
        clear_left = DEPTH;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        fetch_en = 0; stall = 0; flush = 0; prog_we = 0;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        idle();
        prog_we = 1; prog_addr = AW'(a); prog_data = d;
        step();
        prog_we = 0;
    endtask

    task automatic fetch(input logic [31:0] pw, input logic [31:0] pb);
        idle();
        fetch_en = 1; pc_w = pw; pc_b = pb;
        step();
    endtask

    task automatic fetch_all();
        for (int a = 0; a < DEPTH; a++) fetch(32'(a), 32'(4 * a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // clear sequence: fetch requests are ignored, ready rises after DEPTH cycles
        fetch_en = 1;
        for (int c = 0; c < DEPTH; c++) begin
            pc_w = $urandom_range(0, 15);
            pc_b = 4 * $urandom_range(0, 15);
            prog_we = 1; prog_addr = AW'(c); prog_data = $urandom;
            step();
        end
        idle();
        step();
        fetch_all();

        // program load and write-first collision
        write_word(3, 32'h0000_1234);
        fetch(32'd3, 32'd12);
        prog_we = 1; prog_addr = 4'd5; prog_data = 32'hA5A5_A5A5;
        fetch_en = 1; pc_w = 32'd5; pc_b = 32'd20;
        step();
        idle();

        // byte-address alignment and range faults
        fetch(32'd12, 32'd13);
        fetch(32'h0000_0100, 32'h0000_0100);
        fetch(32'd15, 32'd60);
        fetch(32'd16, 32'd64);

        // stall holds across rewrite of the captured word
        write_word(7, 32'h0000_7777);
        fetch(32'd3, 32'd12);
        for (int c = 0; c < 3; c++) begin
            fetch_en = 1; stall = 1; pc_w = 32'd7; pc_b = 32'd28;
            prog_we = (c == 1); prog_addr = 4'd3; prog_data = 32'hDEAD_BEEF;
            step();
        end
        fetch(32'd7, 32'd28);
        fetch(32'd3, 32'd12);

        // flush wins over stall and clears a fault
        fetch(32'h20, 32'd13);
        fetch_en = 1; stall = 1; flush = 1;
        step();
        idle();
        step();

        // asynchronous reset mid-run, then memory reads back cleared
        write_word(9, 32'h1111_2222);
        fetch(32'd9, 32'd36);
        do_reset();
        for (int c = 0; c < DEPTH; c++) begin
            fetch_en = 1; pc_w = 32'(c);
            step();
        end
        fetch_all();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            fetch_en  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            prog_we   = ($urandom_range(0, 2) == 0);
            prog_addr = AW'($urandom_range(0, DEPTH - 1));
            prog_data = $urandom;
            pc_w      = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 19));
            pc_b      = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 70));
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
